fifo_flex: RTL and testbench



---
 rtl/fifo_flex.sv | 103 ++++++++++
 tb/tb_fifo_flex.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous show-ahead FIFO (any DEPTH >= 2) with
// occupancy count, almost flags and flush. Define FIFO_FLEX_ERR_FLAGS_EN for sticky ovf/udf flags.
module fifo_flex #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 2,
  parameter int  AF_TH = DEPTH - 1,
  parameter int  AE_TH = 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    fill_count,
  input  logic             flush,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_clear;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = w_valid & ~w_full;
  assign w_pop   = r_ready & ~w_empty;
  assign w_clear = rst | flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are never visible
  // because data_out is forced to zero whenever the count says empty.
  always_ff @(posedge clk) begin
    if (w_push && !w_clear) r_mem[r_wr_ptr] <= data_in;
  end

  assign data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign almost_full  = (r_count >= CW'(AF_TH));
  assign almost_empty = (r_count <= CW'(AE_TH));
  assign fill_count   = r_count;

`ifdef FIFO_FLEX_ERR_FLAGS_EN
  logic r_ovf_err;
  logic r_udf_err;

  // Clearing wins over a same-cycle error event.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (w_valid && w_full)  r_ovf_err <= 1'b1;
      if (r_ready && w_empty) r_udf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex (DEPTH=5, AF_TH=4, AE_TH=1): directed table,
// corner sequences and randomized traffic against a queue-based reference model.
module tb_fifo_flex;

  localparam int WIDTH = 16;
  localparam int DEPTH = 5;
  localparam int AF_TH = 4;
  localparam int AE_TH = 1;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef FIFO_FLEX_ERR_FLAGS_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             w_valid;
  logic [WIDTH-1:0] data_in;
  logic             r_ready;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    fill_count;
  logic             ovf_err;
  logic             udf_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a queue, sticky errors as bits.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  bit               m_udf;

  always #5 clk = ~clk;

  fifo_flex #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)
  ) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .data_in(data_in),
    .r_ready(r_ready), .data_out(data_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fill_count(fill_count), .flush(flush),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic r, input logic f, input logic wv,
                      input logic rr, input logic [WIDTH-1:0] d);
    bit do_push, do_pop, set_ovf, set_udf;
    do_push = wv && (q.size() < DEPTH);
    do_pop  = rr && (q.size() > 0);
    set_ovf = wv && (q.size() == DEPTH);
    set_udf = rr && (q.size() == 0);
    rst = r; flush = f; w_valid = wv; r_ready = rr; data_in = d;
    @(posedge clk);
    if (r || f) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (E && set_ovf) m_ovf = 1'b1;
      if (E && set_udf) m_udf = 1'b1;
    end
    #1;
  endtask

  // Compare every output with values expected for occupancy cnt.
  task automatic check_state(input string tag, input int cnt, input logic [WIDTH-1:0] dout,
                             input logic ovf, input logic udf);
    check({tag, ".fill_count"},   fill_count,   cnt);
    check({tag, ".fifo_empty"},   fifo_empty,   cnt == 0);
    check({tag, ".fifo_full"},    fifo_full,    cnt == DEPTH);
    check({tag, ".almost_full"},  almost_full,  cnt >= AF_TH);
    check({tag, ".almost_empty"}, almost_empty, cnt <= AE_TH);
    check({tag, ".data_out"},     data_out,     dout);
    check({tag, ".ovf_err"},      ovf_err,      ovf);
    check({tag, ".udf_err"},      udf_err,      udf);
  endtask

  task automatic check_model(input string tag);
    check_state(tag, q.size(), (q.size() > 0) ? q[0] : '0, m_ovf, m_udf);
  endtask

  typedef struct {
    logic             rst;
    logic             flush;
    logic             wv;
    logic             rr;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic [WIDTH-1:0] dout;
    logic             ovf;
    logic             udf;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // rst flush wv rr din | cnt dout ovf udf  (expected after the edge)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 2, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 3, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 4, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 5, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00AA, 5, 16'h0000, E,    1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4, 16'h0001, E,    1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 16'h0002, E,    1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 16'h0003, E,    1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 16'h0004, E,    1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, E,    1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, E,    E   };
    vecs[14] = '{1'b0, 1'b1, 1'b0, 0,    16'h0000, 0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0; data_in = '0;
    m_ovf = 1'b0; m_udf = 1'b0;

    // Directed table: reset, fill past full, drain across wrap, underflow, flush.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].wv, vecs[i].rr, vecs[i].din);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].udf);
    end

    // Concurrent push/pop at count 2 for 20 cycles: count constant, order kept.
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1001);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h2000 + 16'(i));
      check("conc.fill_count", fill_count, 2);
      check_model("conc");
    end
    if (n_fail == 0) check("conc.last_word", data_out, 16'h2012);

    // Full with push and pop together: one pop, push dropped.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h3000 + 16'(i));
    check("full.reached", fifo_full, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    check("fullpp.fill_count", fill_count, DEPTH - 1);
    check("fullpp.data_out", data_out, 16'h2013);
    check_model("fullpp");

    // Flush with w_valid at count 3: word discarded, errors cleared.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("preflush.fill_count", fill_count, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h5555);
    check_state("flush", 0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_state("postflush", 0, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic r, f, wv, rr;
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 31) == 0);
      wv = ($urandom_range(0, 99) < 55);
      rr = ($urandom_range(0, 99) < 50);
      step(r, f, wv, rr, WIDTH'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
